// File: rtl/cpu_pkg.sv
// cpu_pkg: branch-select encodings, 2-bit predictor states and BTB entry layout
// shared by the branch predict unit and its table.
package cpu_pkg;
  typedef enum logic [1:0] {
    BS_SEQ  = 2'b00,
    BS_COND = 2'b01,
    BS_JR   = 2'b10,
    BS_JMP  = 2'b11
  } bs_e;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam int BTB_TAG_W = 8;
  localparam int BTB_TGT_W = 32;

  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [BTB_TGT_W-1:0] target;
  } btb_entry_t;

  function automatic logic [1:0] bht_next(input logic [1:0] c, input logic taken);
    return taken ? (c == ST ? ST : c + 2'd1) : (c == SNT ? SNT : c - 2'd1);
  endfunction
endpackage

// File: rtl/branch_pred_table.sv
// branch_pred_table: direct-mapped BTB plus 2-bit BHT with one async lookup port
// and one training port; lookups see pre-update contents.
module branch_pred_table
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IDX_W = 6,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [WIDTH-1:0] rd_target,
  output logic [1:0]       rd_cnt,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             wr_taken,
  input  logic [WIDTH-1:0] wr_target
);
  localparam int N = 2 ** IDX_W;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] target;
  } entry_t;

  logic [N-1:0]     valid_q, valid_d;
  logic [1:0]       bht_q    [N];
  logic [1:0]       bht_d    [N];
  logic [TAG_W-1:0] tag_q    [N];
  logic [TAG_W-1:0] tag_d    [N];
  logic [WIDTH-1:0] target_q [N];
  logic [WIDTH-1:0] target_d [N];
  entry_t           rd_entry;
  logic             wr_hit;

  always_comb begin
    rd_entry  = '{valid: valid_q[rd_idx], tag: tag_q[rd_idx], target: target_q[rd_idx]};
    rd_valid  = rd_entry.valid;
    rd_tag    = rd_entry.tag;
    rd_target = rd_entry.target;
    rd_cnt    = bht_q[rd_idx];
  end

  // A taken branch that misses allocates and starts weakly taken instead of incrementing.
  always_comb begin
    valid_d  = valid_q;
    bht_d    = bht_q;
    tag_d    = tag_q;
    target_d = target_q;
    wr_hit   = valid_q[wr_idx] && tag_q[wr_idx] == wr_tag;
    if (wr_en) begin
      bht_d[wr_idx] = (wr_taken && !wr_hit) ? WT : bht_next(bht_q[wr_idx], wr_taken);
      if (wr_taken) begin
        valid_d[wr_idx]  = 1'b1;
        tag_d[wr_idx]    = wr_tag;
        target_d[wr_idx] = wr_target;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < N; i++) bht_q[i] <= WNT;
    end else begin
      valid_q <= valid_d;
      bht_q   <= bht_d;
    end
  end

  // Tags and targets are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end
endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: fetch PC register with BTB/BHT prediction, EX-stage branch
// resolution, mispredict flush/redirect and a saturating mispredict counter.
module branch_predict_unit
  import cpu_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               IDX_W    = 6,
  parameter int               TAG_W    = 8,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fetch_en,
  output logic [WIDTH-1:0] pc,
  output logic             pred_taken,
  output logic [WIDTH-1:0] pred_target,
  input  logic             resolve_valid,
  input  logic [WIDTH-1:0] resolve_pc,
  input  logic [1:0]       BS,
  input  logic             PS,
  input  logic             zero,
  input  logic [WIDTH-1:0] BrA,
  input  logic [WIDTH-1:0] RAA,
  input  logic             resolve_pred_taken,
  input  logic [WIDTH-1:0] resolve_pred_target,
  output logic             flush,
  output logic [CNT_W-1:0] mispredict_cnt
);
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [WIDTH-1:0] rd_target;
  logic [1:0]       rd_cnt;
  logic             taken;
  logic [WIDTH-1:0] target, next_correct;
  logic             train;

  branch_pred_table #(.WIDTH(WIDTH), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_table (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (pc_q[IDX_W-1:0]),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_target (rd_target),
    .rd_cnt    (rd_cnt),
    .wr_en     (train),
    .wr_idx    (resolve_pc[IDX_W-1:0]),
    .wr_tag    (resolve_pc[IDX_W+TAG_W-1:IDX_W]),
    .wr_taken  (taken),
    .wr_target (target)
  );

  always_comb begin
    pred_taken   = rd_valid && rd_tag == pc_q[IDX_W+TAG_W-1:IDX_W] && rd_cnt[1];
    pred_target  = pred_taken ? rd_target : '0;
    taken        = BS[1] | (BS[0] & (PS ^ zero));
    target       = BS == BS_JR ? RAA : BrA;
    next_correct = taken ? target : resolve_pc + WIDTH'(1);
    train        = resolve_valid && BS != BS_SEQ;
    flush        = resolve_valid &&
                   (taken != resolve_pred_taken || (taken && target != resolve_pred_target));
    pc_d         = flush ? next_correct : !fetch_en ? pc_q : pred_taken ? pred_target : pc_q + WIDTH'(1);
    cnt_d        = (flush && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
    end
  end

  assign pc             = pc_q;
  assign mispredict_cnt = cnt_q;
endmodule
